// File: rtl/gpr_pkg.sv
// Shared definitions for the GPR writeback path: widths, zero register,
// round-robin state encoding and the buffered writeback entry layout.
package gpr_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned NUM_REGS = 32;
  // Wide enough to hold a count of up to 4 entries.
  localparam int unsigned CNT_W    = 3;

  localparam logic [REG_AW-1:0] ZERO_REG = '0;

  typedef enum logic {
    LAST_ALU = 1'b0,
    LAST_MEM = 1'b1
  } rr_state_t;

  // 37-bit buffer entry: destination register + data.
  typedef struct packed {
    logic [REG_AW-1:0] rw;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // One-hot of a destination register; the zero register maps to no bit.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_AW-1:0] rw);
    reg_onehot = '0;
    if (rw != ZERO_REG) reg_onehot[rw] = 1'b1;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Per-requester writeback buffer.
// Ports:
//   clk, reset      - clock, asynchronous active-low reset
//   push/push_entry - write an entry (caller guarantees not full)
//   pop             - drop the head (caller guarantees head_valid)
//   count           - registered occupancy
//   head_valid      - head may be granted this cycle
//   head            - oldest entry
//   pend            - one-hot OR of valid entries' rw (GPR_WB_SCOREBOARD_EN only)
// Optional feature macro: GPR_WB_SCOREBOARD_EN.
module wb_fifo
  import gpr_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  wb_entry_t        push_entry,
  input  logic             pop,
  output logic [CNT_W-1:0] count,
  output logic             head_valid,
  output wb_entry_t        head
`ifdef GPR_WB_SCOREBOARD_EN
  ,
  output logic [NUM_REGS-1:0] pend
`endif
);

  // Legal depths are powers of two, so pointer overflow is the modulo wrap.
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  wb_entry_t        r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             r_just_pushed;

  // Pointers, occupancy and last-edge push flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_count       <= '0;
      r_just_pushed <= 1'b0;
    end else begin
      if (push) r_wptr <= r_wptr + PTR_W'(1);
      if (pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      r_just_pushed <= push;
    end
  end

  // Entry storage; validity is carried by the pointers so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) r_mem[r_wptr] <= push_entry;
  end

  assign count = r_count;
  assign head  = r_mem[r_rptr];

  // An entry written on the previous edge settles for one cycle before it can
  // be granted; only matters when it is the sole entry.
  assign head_valid = (r_count != '0) && !((r_count == CNT_W'(1)) && r_just_pushed);

`ifdef GPR_WB_SCOREBOARD_EN
  logic [PTR_W-1:0] w_off;

  // Slot i is valid when its distance from the read pointer is below count.
  always_comb begin
    pend  = '0;
    w_off = '0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      w_off = PTR_W'(i) - r_rptr;
      if (CNT_W'(w_off) < r_count) pend = pend | reg_onehot(r_mem[i].rw);
    end
  end
`endif

endmodule

// File: rtl/gpr_wb_arbiter.sv
// Two-requester register-file writeback arbiter (ALU/jal and load paths).
// Each requester has its own FIFO; one head is granted per cycle, ties are
// broken round-robin, and the granted entry is registered onto the write port.
// Ports:
//   clk, reset                 - clock, asynchronous active-low reset
//   alu_req/alu_rw/alu_data    - ALU writeback request; alu_rdy = can accept
//   mem_req/mem_rw/mem_data    - load writeback request; mem_rdy = can accept
//   regWr/Rw/busW              - register-file write port (registered)
//   pend_mask                  - bit i set while a write to register i is buffered
// Optional feature macro: GPR_WB_SCOREBOARD_EN (drives pend_mask; else tied 0).
module gpr_wb_arbiter
  import gpr_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                alu_req,
  input  logic [REG_AW-1:0]   alu_rw,
  input  logic [DATA_W-1:0]   alu_data,
  output logic                alu_rdy,
  input  logic                mem_req,
  input  logic [REG_AW-1:0]   mem_rw,
  input  logic [DATA_W-1:0]   mem_data,
  output logic                mem_rdy,
  output logic                regWr,
  output logic [REG_AW-1:0]   Rw,
  output logic [DATA_W-1:0]   busW,
  output logic [NUM_REGS-1:0] pend_mask
);

  logic [CNT_W-1:0] w_alu_count;
  logic [CNT_W-1:0] w_mem_count;
  logic             w_alu_valid;
  logic             w_mem_valid;
  wb_entry_t        w_alu_head;
  wb_entry_t        w_mem_head;
  wb_entry_t        w_alu_in;
  wb_entry_t        w_mem_in;
  logic             w_alu_push;
  logic             w_mem_push;
  logic             w_gnt_alu;
  logic             w_gnt_mem;
  wb_entry_t        w_gnt_entry;
  rr_state_t        r_state;
  rr_state_t        w_state_nxt;

  // Ready comes from registered occupancy only; held low while in reset.
  assign alu_rdy = reset & (w_alu_count < CNT_W'(FIFO_DEPTH));
  assign mem_rdy = reset & (w_mem_count < CNT_W'(FIFO_DEPTH));

  assign w_alu_push = alu_req & alu_rdy;
  assign w_mem_push = mem_req & mem_rdy;
  assign w_alu_in   = {alu_rw, alu_data};
  assign w_mem_in   = {mem_rw, mem_data};

`ifdef GPR_WB_SCOREBOARD_EN
  logic [NUM_REGS-1:0] w_alu_pend;
  logic [NUM_REGS-1:0] w_mem_pend;
`endif

  wb_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_alu_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (w_alu_push),
    .push_entry (w_alu_in),
    .pop        (w_gnt_alu),
    .count      (w_alu_count),
    .head_valid (w_alu_valid),
    .head       (w_alu_head)
`ifdef GPR_WB_SCOREBOARD_EN
    ,
    .pend       (w_alu_pend)
`endif
  );

  wb_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_mem_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (w_mem_push),
    .push_entry (w_mem_in),
    .pop        (w_gnt_mem),
    .count      (w_mem_count),
    .head_valid (w_mem_valid),
    .head       (w_mem_head)
`ifdef GPR_WB_SCOREBOARD_EN
    ,
    .pend       (w_mem_pend)
`endif
  );

  // Round-robin state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= LAST_MEM;
    else        r_state <= w_state_nxt;
  end

  // Grant selection; state moves only when something is granted.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_alu   = 1'b0;
    w_gnt_mem   = 1'b0;
    if (w_alu_valid && w_mem_valid) begin
      if (r_state == LAST_MEM) w_gnt_alu = 1'b1;
      else                     w_gnt_mem = 1'b1;
    end else if (w_alu_valid) begin
      w_gnt_alu = 1'b1;
    end else if (w_mem_valid) begin
      w_gnt_mem = 1'b1;
    end
    if (w_gnt_alu) w_state_nxt = LAST_ALU;
    if (w_gnt_mem) w_state_nxt = LAST_MEM;
  end

  assign w_gnt_entry = w_gnt_alu ? w_alu_head : w_mem_head;

  // Write port register; zero-register writes are consumed but suppressed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regWr <= 1'b0;
      Rw    <= '0;
      busW  <= '0;
    end else begin
      regWr <= 1'b0;
      Rw    <= '0;
      busW  <= '0;
      if ((w_gnt_alu || w_gnt_mem) && (w_gnt_entry.rw != ZERO_REG)) begin
        regWr <= 1'b1;
        Rw    <= w_gnt_entry.rw;
        busW  <= w_gnt_entry.data;
      end
    end
  end

`ifdef GPR_WB_SCOREBOARD_EN
  assign pend_mask = w_alu_pend | w_mem_pend;
`else
  assign pend_mask = '0;
`endif

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Self-checking bench for gpr_wb_arbiter (FIFO_DEPTH=2). Accepted writes are
// queued per requester; every registered write must match a queue head.
module tb_gpr_wb_arbiter;

`ifdef GPR_WB_SCOREBOARD_EN
  localparam logic SB = 1'b1;
`else
  localparam logic SB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_req, mem_req;
  logic [4:0]  alu_rw, mem_rw;
  logic [31:0] alu_data, mem_data;
  logic        alu_rdy, mem_rdy;
  logic        regWr;
  logic [4:0]  Rw;
  logic [31:0] busW;
  logic [31:0] pend_mask;

  int n_checks = 0;
  int n_fail   = 0;

  logic [36:0] alu_q[$];
  logic [36:0] mem_q[$];

  always #5 clk = ~clk;

  gpr_wb_arbiter #(.FIFO_DEPTH(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .alu_req   (alu_req),
    .alu_rw    (alu_rw),
    .alu_data  (alu_data),
    .alu_rdy   (alu_rdy),
    .mem_req   (mem_req),
    .mem_rw    (mem_rw),
    .mem_data  (mem_data),
    .mem_rdy   (mem_rdy),
    .regWr     (regWr),
    .Rw        (Rw),
    .busW      (busW),
    .pend_mask (pend_mask)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle from just after an edge; returns whether each side is accepted.
  task automatic cycle(input logic av, input logic [4:0] arw, input logic [31:0] ad,
                       input logic mv, input logic [4:0] mrw, input logic [31:0] md,
                       output logic a_acc, output logic m_acc);
    alu_req  = av;  alu_rw = arw; alu_data = ad;
    mem_req  = mv;  mem_rw = mrw; mem_data = md;
    a_acc    = av && alu_rdy;
    m_acc    = mv && mem_rdy;
    if (a_acc && arw != 5'd0) alu_q.push_back({arw, ad});
    if (m_acc && mrw != 5'd0) mem_q.push_back({mrw, md});
    @(posedge clk);
    #1;
    alu_req = 1'b0;
    mem_req = 1'b0;
  endtask

  task automatic idle(input int n);
    logic a, m;
    for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, a, m);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    alu_req = 1'b0;
    mem_req = 1'b0;
    alu_q.delete();
    mem_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
  endtask

  // Scoreboard: each write must equal a requester's oldest outstanding entry.
  always @(negedge clk) begin
    logic [37:0] obs, exp;
    obs = {regWr, Rw, busW};
    if (regWr) begin
      if (alu_q.size() > 0 && alu_q[0] == obs[36:0]) begin
        exp = {1'b1, alu_q.pop_front()};
      end else if (mem_q.size() > 0) begin
        exp = {1'b1, mem_q.pop_front()};
      end else if (alu_q.size() > 0) begin
        exp = {1'b1, alu_q.pop_front()};
      end else begin
        exp = '0;
      end
      check("sb_write", 64'(obs), 64'(exp));
    end else begin
      check("idle_out", 64'(obs), 64'd0);
    end
  end

  initial begin
    logic a, m;
    int   held;

    reset    = 1'b0;
    alu_req  = 1'b0; alu_rw = '0; alu_data = '0;
    mem_req  = 1'b0; mem_rw = '0; mem_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_regWr", 64'(regWr), 64'd0);
    check("rst_pend",  64'(pend_mask), 64'd0);
    check("rst_alu_rdy", 64'(alu_rdy), 64'd0);
    check("rst_mem_rdy", 64'(mem_rdy), 64'd0);
    reset = 1'b1;
    #1;
    check("rel_alu_rdy", 64'(alu_rdy), 64'd1);
    check("rel_mem_rdy", 64'(mem_rdy), 64'd1);

    // Single ALU write: output two edges after accept, pend bit 5 meanwhile.
    cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, a, m);
    check("w1_e0_regWr", 64'(regWr), 64'd0);
    check("w1_e0_pend",  64'(pend_mask), SB ? 64'h20 : 64'd0);
    idle(1);
    check("w1_e1_regWr", 64'(regWr), 64'd0);
    check("w1_e1_pend",  64'(pend_mask), SB ? 64'h20 : 64'd0);
    idle(1);
    check("w1_e2_out",  64'({regWr, Rw, busW}), 64'({1'b1, 5'd5, 32'hDEADBEEF}));
    check("w1_e2_pend", 64'(pend_mask), 64'd0);
    idle(1);
    check("w1_e3_regWr", 64'(regWr), 64'd0);

    // Tie after reset: ALU first, MEM next cycle.
    do_reset();
    cycle(1'b1, 5'd1, 32'h1111_0001, 1'b1, 5'd2, 32'h2222_0002, a, m);
    check("tie_e0_pend", 64'(pend_mask), SB ? 64'h6 : 64'd0);
    idle(1);
    check("tie_e1_regWr", 64'(regWr), 64'd0);
    idle(1);
    check("tie_e2_out", 64'({regWr, Rw}), 64'({1'b1, 5'd1}));
    idle(1);
    check("tie_e3_out", 64'({regWr, Rw}), 64'({1'b1, 5'd2}));
    idle(1);
    check("tie_e4_regWr", 64'(regWr), 64'd0);

    // Three back-to-back ALU requests into a depth-2 buffer.
    idle(2);
    cycle(1'b1, 5'd10, 32'hA0A0_000A, 1'b0, 5'd0, 32'd0, a, m);
    check("bp_e0_rdy", 64'(alu_rdy), 64'd1);
    cycle(1'b1, 5'd11, 32'hA0A0_000B, 1'b0, 5'd0, 32'd0, a, m);
    check("bp_e1_rdy", 64'(alu_rdy), 64'd0);
    held = 0;
    a    = 1'b0;
    for (int i = 0; i < 10 && !a; i++) begin
      cycle(1'b1, 5'd12, 32'hA0A0_000C, 1'b0, 5'd0, 32'd0, a, m);
      if (!a) held++;
    end
    check("bp_accepted", 64'(a), 64'd1);
    check("bp_held", 64'(held), 64'd1);
    idle(6);
    check("bp_drain", 64'(alu_q.size()), 64'd0);

    // Zero-register loads: consumed silently, backpressure releases.
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h0BAD_0000, a, m);
    check("z_e0_pend", 64'(pend_mask), 64'd0);
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h0BAD_0001, a, m);
    check("z_e1_rdy", 64'(mem_rdy), 64'd0);
    idle(4);
    check("z_rdy", 64'(mem_rdy), 64'd1);
    check("z_pend", 64'(pend_mask), 64'd0);

    // Reset with two entries per buffer: contents dropped, nothing emitted.
    cycle(1'b1, 5'd3, 32'h3333_0003, 1'b1, 5'd6, 32'h6666_0006, a, m);
    cycle(1'b1, 5'd4, 32'h4444_0004, 1'b1, 5'd7, 32'h7777_0007, a, m);
    check("mr_full", 64'({alu_rdy, mem_rdy}), 64'd0);
    check("mr_pend", 64'(pend_mask), SB ? 64'hD8 : 64'd0);
    reset = 1'b0;
    alu_q.delete();
    mem_q.delete();
    #1;
    check("mr_out", 64'({regWr, Rw, busW}), 64'd0);
    check("mr_pend0", 64'(pend_mask), 64'd0);
    check("mr_rdy0", 64'({alu_rdy, mem_rdy}), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("mr_rdy1", 64'({alu_rdy, mem_rdy}), 64'h3);
    idle(6);
    check("mr_pend1", 64'(pend_mask), 64'd0);

    // Random traffic, order checked by the scoreboard.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom_range(0, 1)), 5'($urandom), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom), $urandom, a, m);
    end
    idle(12);
    check("rnd_alu_drain", 64'(alu_q.size()), 64'd0);
    check("rnd_mem_drain", 64'(mem_q.size()), 64'd0);
    check("rnd_pend", 64'(pend_mask), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
